// File: rtl/cntr_gen.sv
// cntr_gen: parameterised up/down modulo counter with parallel load,
// synchronous clear, optional saturation and a sticky overflow flag.
//
// Parameters:
//   WIDTH  counter width in bits (2..32)
//   count modulus MOD, 2..2^WIDTH; the count range is 0..MOD-1
//   SAT    0 = wrap at the terminal value, 1 = hold at the terminal value
//
// Ports:
//   clk    sole clock, rising edge
//   rst    synchronous active-high reset (y=0, ovf=0)
//   clr    synchronous clear of y and ovf
//   load   synchronous parallel load of d (clamped to MOD-1)
//   d      load value
//   en     count enable
//   up_dn  direction, 1 = up, 0 = down
//   y      registered count value
//   tc     combinational terminal-count strobe
//   ovf    registered sticky overflow/underflow flag
module cntr_gen #(
    parameter int unsigned     WIDTH = 4,
    parameter longint unsigned MOD   = 16,
    parameter bit              SAT   = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic             en,
    input  logic             up_dn,
    output logic [WIDTH-1:0] y,
    output logic             tc,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] MAX_VAL    = WIDTH'(MOD - 64'd1);
    localparam bit               FULL_RANGE = (MOD == (64'd1 << WIDTH));

    // When the modulus fills the whole register and we wrap, the plain
    // adder/subtractor already rolls over correctly, so the terminal-value
    // override is only needed for saturation or a short modulus.
    localparam bit NEED_EDGE_FIX = SAT || !FULL_RANGE;

    logic             at_max;
    logic             at_zero;
    logic             at_term;
    logic [WIDTH-1:0] inc_val;
    logic [WIDTH-1:0] dec_val;
    logic [WIDTH-1:0] load_val;

    // Terminal detection, next-value candidates for each direction and the
    // clamped load value. The terminal value depends on the direction being
    // requested this cycle, so a direction change is seen immediately.
    always_comb begin
        at_max   = (y == MAX_VAL);
        at_zero  = (y == '0);
        at_term  = up_dn ? at_max : at_zero;

        inc_val  = y + 1'b1;
        if (NEED_EDGE_FIX && at_max) begin
            inc_val = SAT ? MAX_VAL : '0;
        end

        dec_val  = y - 1'b1;
        if (NEED_EDGE_FIX && at_zero) begin
            dec_val = SAT ? '0 : MAX_VAL;
        end

        load_val = (d > MAX_VAL) ? MAX_VAL : d;
    end

    // The strobe only fires when the counter would actually step past the
    // terminal value, so any higher-priority control masks it.
    always_comb begin
        tc = en && !load && !clr && !rst && at_term;
    end

    // Count register and sticky flag. Priority is rst, clr, load, en, hold.
    // ovf is set on exactly the edges where tc is high, which is the enable
    // branch with the counter sitting on its terminal value.
    always_ff @(posedge clk) begin
        if (rst) begin
            y   <= '0;
            ovf <= 1'b0;
        end else if (clr) begin
            y   <= '0;
            ovf <= 1'b0;
        end else if (load) begin
            y   <= load_val;
        end else if (en) begin
            y   <= up_dn ? inc_val : dec_val;
            if (at_term) begin
                ovf <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cntr_gen.sv
// tb_cntr_gen: drives three cntr_gen instances with a shared directed
// stimulus and checks them against an arithmetic model every cycle, plus
// hand-computed literal expectations for the targeted instance.
//
// Instances:
//   inst 0  WIDTH=4 MOD=16 SAT=0  (full-range wrap)
//   inst 1  WIDTH=4 MOD=10 SAT=0  (short modulus wrap)
//   inst 2  WIDTH=4 MOD=10 SAT=1  (short modulus saturate)
module tb_cntr_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       clr;
    logic       load;
    logic       en;
    logic       up_dn;
    logic [3:0] d;

    logic [3:0] y0, y1, y2;
    logic       tc0, tc1, tc2;
    logic       ovf0, ovf1, ovf2;

    int total = 0;
    int bad   = 0;

    int mdl_mod [3] = '{16, 10, 10};
    bit mdl_sat [3] = '{1'b0, 1'b0, 1'b1};
    int mdl_y   [3] = '{0, 0, 0};
    bit mdl_ovf [3] = '{1'b0, 1'b0, 1'b0};
    bit mdl_valid   = 1'b0;

    typedef struct {
        string nm;
        int    inst;
        int    ey;
        int    etc;
        int    eovf;
    } lit_t;

    lit_t lit_q[$];

    cntr_gen #(.WIDTH(4), .MOD(16), .SAT(1'b0)) dut0 (
        .clk(clk), .rst(rst), .clr(clr), .load(load), .d(d),
        .en(en), .up_dn(up_dn), .y(y0), .tc(tc0), .ovf(ovf0)
    );

    cntr_gen #(.WIDTH(4), .MOD(10), .SAT(1'b0)) dut1 (
        .clk(clk), .rst(rst), .clr(clr), .load(load), .d(d),
        .en(en), .up_dn(up_dn), .y(y1), .tc(tc1), .ovf(ovf1)
    );

    cntr_gen #(.WIDTH(4), .MOD(10), .SAT(1'b1)) dut2 (
        .clk(clk), .rst(rst), .clr(clr), .load(load), .d(d),
        .en(en), .up_dn(up_dn), .y(y2), .tc(tc2), .ovf(ovf2)
    );

    // Free-running 10-unit clock
    always #5 clk = ~clk;

    function automatic logic [3:0] act_y(int i);
        case (i)
            0:       return y0;
            1:       return y1;
            default: return y2;
        endcase
    endfunction

    function automatic logic act_tc(int i);
        case (i)
            0:       return tc0;
            1:       return tc1;
            default: return tc2;
        endcase
    endfunction

    function automatic logic act_ovf(int i);
        case (i)
            0:       return ovf0;
            1:       return ovf1;
            default: return ovf2;
        endcase
    endfunction

    // Terminal strobe derived from the rules: an enabled step with no
    // overriding control while sitting on the end of the range in the
    // direction of travel.
    function automatic bit model_tc(int i);
        bit term;
        term = up_dn ? (mdl_y[i] == mdl_mod[i] - 1) : (mdl_y[i] == 0);
        return mdl_valid && en && !load && !clr && !rst && term;
    endfunction

    // Behavioural model: modulo arithmetic for wrap, min/max for saturate
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            bit t;
            t = model_tc(i);
            if (rst) begin
                mdl_y[i]   = 0;
                mdl_ovf[i] = 1'b0;
            end else if (!mdl_valid) begin
                mdl_y[i] = 0;
            end else if (clr) begin
                mdl_y[i]   = 0;
                mdl_ovf[i] = 1'b0;
            end else if (load) begin
                mdl_y[i] = (int'(d) >= mdl_mod[i]) ? mdl_mod[i] - 1 : int'(d);
            end else if (en) begin
                if (up_dn) begin
                    if (mdl_sat[i]) mdl_y[i] = (mdl_y[i] + 1 > mdl_mod[i] - 1) ? mdl_mod[i] - 1 : mdl_y[i] + 1;
                    else            mdl_y[i] = (mdl_y[i] + 1) % mdl_mod[i];
                end else begin
                    if (mdl_sat[i]) mdl_y[i] = (mdl_y[i] - 1 < 0) ? 0 : mdl_y[i] - 1;
                    else            mdl_y[i] = (mdl_y[i] - 1 + mdl_mod[i]) % mdl_mod[i];
                end
                if (t) mdl_ovf[i] = 1'b1;
            end
        end
        if (rst) mdl_valid = 1'b1;
    end

    task automatic cmp(input string nm, input int inst, input string what,
                       input logic [3:0] act, input logic [3:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s inst=%0d %s got=%0d want=%0d @%0t",
                     nm, inst, what, act, exp, $time);
        end
    endtask

    // Single compare process: model check every cycle after the first
    // reset, then any pending hand-computed expectations.
    always @(negedge clk) begin
        if (mdl_valid) begin
            for (int i = 0; i < 3; i++) begin
                cmp("model", i, "y",   act_y(i),          4'(mdl_y[i]));
                cmp("model", i, "tc",  4'(act_tc(i)),     4'(model_tc(i)));
                cmp("model", i, "ovf", 4'(act_ovf(i)),    4'(mdl_ovf[i]));
            end
        end
        while (lit_q.size() > 0) begin
            lit_t e;
            e = lit_q.pop_front();
            cmp(e.nm, e.inst, "y", act_y(e.inst), 4'(e.ey));
            if (e.etc >= 0)  cmp(e.nm, e.inst, "tc",  4'(act_tc(e.inst)),  4'(e.etc));
            if (e.eovf >= 0) cmp(e.nm, e.inst, "ovf", 4'(act_ovf(e.inst)), 4'(e.eovf));
        end
    end

    // Drive one cycle of inputs after the falling edge, then wait just past
    // the rising edge that consumes them.
    task automatic applyStimulus(input bit r, input bit c, input bit l,
                                 input logic [3:0] dv, input bit e, input bit u);
        @(negedge clk);
        #2;
        rst   = r;
        clr   = c;
        load  = l;
        d     = dv;
        en    = e;
        up_dn = u;
        @(posedge clk);
        #1;
    endtask

    // Queue a literal expectation; -1 skips tc or ovf
    task automatic checkOutput(input string nm, input int inst, input int ey,
                               input int etc, input int eovf);
        lit_t e;
        e.nm   = nm;
        e.inst = inst;
        e.ey   = ey;
        e.etc  = etc;
        e.eovf = eovf;
        lit_q.push_back(e);
    endtask

    // Directed scenario sequence
    initial begin
        int down_exp [5] = '{2, 1, 0, 9, 8};
        int sat_exp  [4] = '{8, 9, 9, 9};

        rst = 1'b0; clr = 1'b0; load = 1'b0; en = 1'b0; up_dn = 1'b1; d = 4'd0;

        // reset with a down-count request that would otherwise strobe at 0
        applyStimulus(1, 0, 0, 4'd0, 1, 0);
        for (int i = 0; i < 3; i++) checkOutput("reset", i, 0, 0, 0);

        // full-range up count through the wrap
        for (int k = 1; k <= 17; k++) begin
            applyStimulus(0, 0, 0, 4'd0, 1, 1);
            checkOutput("up_wrap", 0, k % 16, (k == 15) ? 1 : 0, (k >= 16) ? 1 : 0);
        end

        // short-modulus down count from 3 across the underflow
        applyStimulus(0, 1, 0, 4'd0, 0, 1);
        checkOutput("clear", 1, 0, 0, 0);
        applyStimulus(0, 0, 1, 4'd3, 1, 0);
        checkOutput("load3", 1, 3, 0, 0);
        for (int k = 1; k <= 5; k++) begin
            applyStimulus(0, 0, 0, 4'd0, 1, 0);
            checkOutput("down_wrap", 1, down_exp[k-1], (k == 3) ? 1 : 0, (k >= 4) ? 1 : 0);
        end

        // short-modulus saturating up count from 7
        applyStimulus(0, 1, 0, 4'd0, 0, 1);
        applyStimulus(0, 0, 1, 4'd7, 0, 1);
        checkOutput("load7", 2, 7, 0, 0);
        for (int k = 1; k <= 4; k++) begin
            applyStimulus(0, 0, 0, 4'd0, 1, 1);
            checkOutput("sat_up", 2, sat_exp[k-1], (k >= 2) ? 1 : 0, (k >= 3) ? 1 : 0);
        end

        // saturating down count held at zero
        applyStimulus(0, 1, 0, 4'd0, 0, 1);
        applyStimulus(0, 0, 0, 4'd0, 1, 0);
        checkOutput("sat_down", 2, 0, 1, 1);
        checkOutput("wrap_down", 1, 9, 0, 1);

        // load clamp, then clr+load together
        applyStimulus(0, 0, 1, 4'd12, 0, 1);
        checkOutput("clamp", 1, 9, 0, 1);
        checkOutput("noclamp", 0, 12, 0, -1);
        applyStimulus(0, 1, 1, 4'd5, 1, 1);
        checkOutput("clr_load", 1, 0, 0, 0);
        checkOutput("clr_load", 0, 0, 0, 0);

        // set ovf, load 6, then reset overriding en and load
        applyStimulus(0, 0, 1, 4'd15, 0, 1);
        checkOutput("load15", 0, 15, 0, 0);
        applyStimulus(0, 0, 0, 4'd0, 1, 1);
        checkOutput("wrap16", 0, 0, 0, 1);
        applyStimulus(0, 0, 1, 4'd6, 0, 1);
        checkOutput("load6", 0, 6, 0, 1);
        applyStimulus(1, 0, 1, 4'd9, 1, 1);
        checkOutput("mid_rst", 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 4'd0, 1, 1);
        checkOutput("restart", 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 4'd0, 1, 1);
        checkOutput("restart", 0, 2, 0, 0);

        // direction toggle every cycle from 4
        applyStimulus(0, 0, 1, 4'd4, 0, 1);
        checkOutput("load4", 0, 4, 0, 0);
        for (int k = 1; k <= 4; k++) begin
            applyStimulus(0, 0, 0, 4'd0, 1, (k % 2 == 1) ? 1'b1 : 1'b0);
            checkOutput("toggle", 0, (k % 2 == 1) ? 5 : 4, 0, 0);
        end

        // hold with enable low
        for (int k = 1; k <= 2; k++) begin
            applyStimulus(0, 0, 0, 4'd0, 0, 1);
            checkOutput("hold", 0, 4, 0, 0);
        end

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
